// File: rtl/fpu_result_streamer.sv
// FIFO-buffered serializer: 32-bit FPU results out as LSB-first byte frames.
// Define FPU_STREAM_CHECKSUM_EN to append an XOR checksum byte to every frame.
module fpu_result_streamer #(
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [7:0]    out_byte,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_first,
    output logic          out_last,
    output logic [LW-1:0] fifo_level,
    output logic          busy
);
    localparam int PW = $clog2(DEPTH);
`ifdef FPU_STREAM_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif
    localparam logic [2:0]    LAST_IDX   = 3'(NB - 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    logic [31:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;

    state_t        r_state;
    logic [23:0]   r_shift;      // bytes 1..3 of the frame; byte 0 is loaded straight into r_out_byte
    logic [2:0]    r_idx;
    logic [7:0]    r_out_byte;
    logic          r_out_valid;
    logic          r_out_first;
    logic          r_out_last;
`ifdef FPU_STREAM_CHECKSUM_EN
    logic [7:0]    r_csum;
`endif

    logic          w_empty;
    logic          w_push;
    logic          w_hs;
    logic          w_frame_end;
    logic          w_pop;
    logic [31:0]   w_head;
    logic [7:0]    w_next_byte;

    assign w_empty     = (r_level == '0);
    assign in_ready    = !rst && (r_level != FULL_LEVEL);
    assign w_push      = in_valid && in_ready;
    assign w_hs        = r_out_valid && out_ready;
    assign w_frame_end = w_hs && (r_idx == LAST_IDX);
    // Pop either to start from idle or to chain the next frame with no bubble.
    assign w_pop       = !w_empty && ((r_state == IDLE) || w_frame_end);
    assign w_head      = r_mem[r_rd_ptr];

`ifdef FPU_STREAM_CHECKSUM_EN
    assign w_next_byte = (r_idx == 3'd3) ? (r_csum ^ r_out_byte) : r_shift[7:0];
`else
    assign w_next_byte = r_shift[7:0];
`endif

    // NOTE: the storage array is deliberately not reset; r_level gates every read, so stale words are never seen.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LW'(1);
            end else if (!w_push && w_pop) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_idx       <= '0;
            r_out_byte  <= '0;
            r_out_valid <= 1'b0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
`ifdef FPU_STREAM_CHECKSUM_EN
            r_csum      <= '0;
`endif
        end else if (w_pop) begin
            r_state     <= SEND;
            r_shift     <= w_head[31:8];
            r_idx       <= '0;
            r_out_byte  <= w_head[7:0];
            r_out_valid <= 1'b1;
            r_out_first <= 1'b1;
            r_out_last  <= 1'b0;
`ifdef FPU_STREAM_CHECKSUM_EN
            r_csum      <= '0;
`endif
        end else if (w_frame_end) begin
            r_state     <= IDLE;
            r_out_byte  <= '0;
            r_out_valid <= 1'b0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_hs) begin
            r_shift     <= r_shift >> 8;
            r_idx       <= r_idx + 3'd1;
            r_out_byte  <= w_next_byte;
            r_out_first <= 1'b0;
            r_out_last  <= ((r_idx + 3'd1) == LAST_IDX);
`ifdef FPU_STREAM_CHECKSUM_EN
            r_csum      <= r_csum ^ r_out_byte;
`endif
        end
    end

    assign out_byte   = r_out_byte;
    assign out_valid  = r_out_valid;
    assign out_first  = r_out_first;
    assign out_last   = r_out_last;
    assign fifo_level = r_level;
    assign busy       = !w_empty || (r_state == SEND);

endmodule

// File: tb/tb_fpu_result_streamer.sv
// Directed bench for fpu_result_streamer; byte handshakes are logged at the falling edge.
module tb_fpu_result_streamer;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef FPU_STREAM_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    out_byte;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_first;
    logic          out_last;
    logic [LW-1:0] fifo_level;
    logic          busy;

    typedef struct {
        int         cyc;
        logic [9:0] d;      // {last, first, byte}
    } cap_t;

    cap_t       cap_q[$];
    logic [9:0] exp_q[$];
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;

    fpu_result_streamer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_first  (out_first),
        .out_last   (out_last),
        .fifo_level (fifo_level),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cap_t e;
        cyc++;
        if (!rst && out_valid && out_ready) begin
            e.cyc = cyc;
            e.d   = {out_last, out_first, out_byte};
            cap_q.push_back(e);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add_frame(input logic [31:0] w);
        for (int b = 0; b < 4; b++) begin
            exp_q.push_back({(NB == 4 && b == 3), (b == 0), w[8*b +: 8]});
        end
`ifdef FPU_STREAM_CHECKSUM_EN
        exp_q.push_back({1'b1, 1'b0, w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24]});
`endif
    endfunction

    task automatic wait_bytes(input int n, input int max_cyc, output bit to);
        int k = 0;
        while (cap_q.size() < n && k < max_cyc) begin
            tick();
            k++;
        end
        to = (cap_q.size() < n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_vec++;
        if ({out_valid, out_first, out_last, busy, in_ready} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 00000", {out_valid, out_first, out_last, busy, in_ready});
        end
        n_vec++;
        if (out_byte !== 8'h00 || fifo_level !== '0) begin
            n_err++;
            $display("FAIL reset_data: got byte=%h level=%0d expected byte=00 level=0", out_byte, fifo_level);
        end
        rst = 1'b0;
        tick();
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_single();
        bit to;
        cap_q.delete();
        exp_q.delete();
        add_frame(32'h3F800000);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h3F800000;
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || fifo_level !== LW'(1)) begin
            n_err++;
            $display("FAIL single_accept: got valid=%b level=%0d expected valid=0 level=1", out_valid, fifo_level);
        end
        tick();
        n_vec++;
        if ({out_valid, out_first, out_byte} !== {1'b1, 1'b1, 8'h00}) begin
            n_err++;
            $display("FAIL single_latency: got valid=%b first=%b byte=%h expected 1 1 00", out_valid, out_first, out_byte);
        end
        wait_bytes(NB, 20, to);
        tick();
        n_vec++;
        if (to) begin
            n_err++;
            $display("FAIL single_timeout: got %0d bytes expected %0d", cap_q.size(), NB);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (i >= cap_q.size() || cap_q[i].d !== exp_q[i] || cap_q[i].cyc !== cap_q[0].cyc + i) begin
                n_err++;
                $display("FAIL single_byte[%0d]: got %h expected %h contiguous", i,
                         (i < cap_q.size()) ? cap_q[i].d : 10'hx, exp_q[i]);
            end
        end
        n_vec++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_byte !== 8'h00) begin
            n_err++;
            $display("FAIL single_idle: got busy=%b valid=%b byte=%h expected 0 0 00", busy, out_valid, out_byte);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        cap_q.delete();
        exp_q.delete();
        add_frame(32'h3F800000);
        add_frame(32'h40490FDB);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h3F800000;
        tick();
        in_data = 32'h40490FDB;
        tick();
        in_valid = 1'b0;
        wait_bytes(2 * NB, 40, to);
        tick();
        n_vec++;
        if (to) begin
            n_err++;
            $display("FAIL b2b_timeout: got %0d bytes expected %0d", cap_q.size(), 2 * NB);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (i >= cap_q.size() || cap_q[i].d !== exp_q[i] || cap_q[i].cyc !== cap_q[0].cyc + i) begin
                n_err++;
                $display("FAIL b2b_byte[%0d]: got %h expected %h contiguous", i,
                         (i < cap_q.size()) ? cap_q[i].d : 10'hx, exp_q[i]);
            end
        end
    endtask

    task automatic test_full();
        logic [31:0] w [1:6];
        int          acc = 1;
        bit          took;
        bit          to;
        for (int k = 1; k <= 6; k++) begin
            w[k] = 32'h03020100 + 32'h10101010 * 32'(k);
        end
        cap_q.delete();
        exp_q.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_data = w[(acc > 6) ? 6 : acc];
            took    = in_ready;
            tick();
            if (took) acc++;
        end
        in_data = w[6];
        n_vec++;
        if (acc - 1 !== 5) begin
            n_err++;
            $display("FAIL full_accepted: got %0d words expected 5", acc - 1);
        end
        n_vec++;
        if ({in_ready, busy, out_valid, out_first} !== 4'b0111 || fifo_level !== LW'(4)) begin
            n_err++;
            $display("FAIL full_state: got rdy/busy/valid/first=%b level=%0d expected 0111 level=4",
                     {in_ready, busy, out_valid, out_first}, fifo_level);
        end
        n_vec++;
        if (out_byte !== 8'h10) begin
            n_err++;
            $display("FAIL full_head: got %h expected 10", out_byte);
        end
        for (int k = 1; k <= 6; k++) add_frame(w[k]);
        out_ready = 1'b1;
        repeat (NB - 1) tick();
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_ready_early: got %b expected 0", in_ready);
        end
        tick();
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL full_ready_rise: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        wait_bytes(6 * NB, 80, to);
        tick();
        n_vec++;
        if (to) begin
            n_err++;
            $display("FAIL full_timeout: got %0d bytes expected %0d", cap_q.size(), 6 * NB);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (i >= cap_q.size() || cap_q[i].d !== exp_q[i]) begin
                n_err++;
                $display("FAIL full_byte[%0d]: got %h expected %h", i,
                         (i < cap_q.size()) ? cap_q[i].d : 10'hx, exp_q[i]);
            end
        end
    endtask

    task automatic test_stall();
        bit to;
        cap_q.delete();
        exp_q.delete();
        add_frame(32'h3F800000);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h3F800000;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (out_byte !== 8'h80) begin
            n_err++;
            $display("FAIL stall_pre: got %h expected 80", out_byte);
        end
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++;
            if ({out_valid, out_first, out_last, out_byte} !== {3'b100, 8'h80}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got %b expected 10010000000", c,
                         {out_valid, out_first, out_last, out_byte});
            end
        end
        out_ready = 1'b1;
        tick();
        n_vec++;
        if (out_byte !== 8'h3F || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL stall_resume: got valid=%b byte=%h expected 1 3f", out_valid, out_byte);
        end
        wait_bytes(NB, 20, to);
        tick();
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (i >= cap_q.size() || cap_q[i].d !== exp_q[i]) begin
                n_err++;
                $display("FAIL stall_byte[%0d]: got %h expected %h", i,
                         (i < cap_q.size()) ? cap_q[i].d : 10'hx, exp_q[i]);
            end
        end
    endtask

    task automatic test_push_pop();
        logic [31:0] p [12];
        int          sent = 3;
        int          guard = 0;
        bit          to;
        cap_q.delete();
        exp_q.delete();
        for (int i = 0; i < 12; i++) begin
            p[i] = 32'hC0804000 + 32'h01010101 * 32'(i);
            add_frame(p[i]);
        end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = p[i];
            tick();
        end
        in_valid = 1'b0;
        n_vec++;
        if (fifo_level !== LW'(2)) begin
            n_err++;
            $display("FAIL pp_setup: got level=%0d expected 2", fifo_level);
        end
        out_ready = 1'b1;
        // Push exactly on the edge that pops, so level must stay put.
        while (sent < 12 && guard < 200) begin
            if (out_valid && out_last) begin
                in_valid = 1'b1;
                in_data  = p[sent];
                tick();
                in_valid = 1'b0;
                sent++;
                n_vec++;
                if (fifo_level !== LW'(2)) begin
                    n_err++;
                    $display("FAIL pp_level[%0d]: got %0d expected 2", sent, fifo_level);
                end
            end else begin
                tick();
            end
            guard++;
        end
        n_vec++;
        if (sent !== 12) begin
            n_err++;
            $display("FAIL pp_sent: got %0d words expected 12", sent);
        end
        wait_bytes(12 * NB, 200, to);
        tick();
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (i >= cap_q.size() || cap_q[i].d !== exp_q[i]) begin
                n_err++;
                $display("FAIL pp_byte[%0d]: got %h expected %h", i,
                         (i < cap_q.size()) ? cap_q[i].d : 10'hx, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'hAABBCC00 + 32'(i);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        rst       = 1'b1;
        tick();
        n_vec++;
        if ({out_valid, busy} !== 2'b00 || fifo_level !== '0 || out_byte !== 8'h00) begin
            n_err++;
            $display("FAIL rstmid_state: got valid=%b busy=%b level=%0d byte=%h expected 0 0 0 00",
                     out_valid, busy, fifo_level, out_byte);
        end
        rst       = 1'b0;
        out_ready = 1'b1;
        cap_q.delete();
        exp_q.delete();
        add_frame(32'h40490FDB);
        in_valid = 1'b1;
        in_data  = 32'h40490FDB;
        tick();
        in_valid = 1'b0;
        wait_bytes(NB, 20, to);
        repeat (4) tick();
        n_vec++;
        if (cap_q.size() !== NB || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_count: got %0d bytes busy=%b expected %0d bytes busy=0", cap_q.size(), busy, NB);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (i >= cap_q.size() || cap_q[i].d !== exp_q[i]) begin
                n_err++;
                $display("FAIL rstmid_byte[%0d]: got %h expected %h", i,
                         (i < cap_q.size()) ? cap_q[i].d : 10'hx, exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_stall();
        test_push_pop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
